// File: rtl/intersection_ctrl_if.sv
// Request inputs and lamp/status outputs of the intersection controller.
// The bench drives through the master modport; the controller uses the slave modport.
interface intersection_ctrl_if;
    logic       i_side_req;
    logic       i_ped_req;
    logic       i_night;
    logic [2:0] o_main;
    logic [2:0] o_side;
    logic       o_walk;
    logic [2:0] o_state;

    modport master (
        output i_side_req, i_ped_req, i_night,
        input  o_main, o_side, o_walk, o_state
    );

    modport slave (
        input  i_side_req, i_ped_req, i_night,
        output o_main, o_side, o_walk, o_state
    );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-road traffic-light controller with a pedestrian walk phase and a night flash mode.
// Lamps are decoded from registered state only, so they change on the state edge.
module intersection_ctrl #(
    parameter int CNT_W      = 8,
    parameter int RED_CLR    = 2,
    parameter int MAIN_GREEN = 20,
    parameter int SIDE_GREEN = 10,
    parameter int YELLOW     = 3,
    parameter int PED_WALK   = 8,
    parameter int FLASH_HALF = 4
) (
    input logic                clk,
    input logic                reset,
    intersection_ctrl_if.slave bus
);
    localparam int LIM = 1 << CNT_W;

    if (RED_CLR < 1 || RED_CLR >= LIM || MAIN_GREEN < 1 || MAIN_GREEN >= LIM ||
        SIDE_GREEN < 1 || SIDE_GREEN >= LIM || YELLOW < 1 || YELLOW >= LIM ||
        PED_WALK < 1 || PED_WALK >= LIM || FLASH_HALF < 1 || FLASH_HALF >= LIM ||
        PED_WALK > SIDE_GREEN) begin : g_bad_params
        $fatal(1, "intersection_ctrl: illegal duration parameters");
    end

    typedef enum logic [2:0] {
        AR_M  = 3'd0,
        M_GRN = 3'd1,
        M_YEL = 3'd2,
        AR_S  = 3'd3,
        S_GRN = 3'd4,
        S_YEL = 3'd5,
        FLASH = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] RED_LD   = CNT_W'(RED_CLR - 1);
    localparam logic [CNT_W-1:0] MAIN_LD  = CNT_W'(MAIN_GREEN - 1);
    localparam logic [CNT_W-1:0] SIDE_LD  = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LD   = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] WALK_THR = CNT_W'(SIDE_GREEN - PED_WALK);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_latch_q, ped_latch_d;
    logic             walk_active_q, walk_active_d;
    logic             f_q, f_d;
    logic             expired, demand, enter_sgrn;

    function automatic logic [CNT_W-1:0] load_val(input state_e s);
        case (s)
            M_GRN:        return MAIN_LD;
            M_YEL, S_YEL: return YEL_LD;
            S_GRN:        return SIDE_LD;
            FLASH:        return FLASH_LD;
            default:      return RED_LD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= AR_M;
            cnt_q         <= RED_LD;
            ped_latch_q   <= 1'b0;
            walk_active_q <= 1'b0;
            f_q           <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_latch_q   <= ped_latch_d;
            walk_active_q <= walk_active_d;
            f_q           <= f_d;
        end
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        expired = (cnt_q == '0);
        demand  = bus.i_side_req | ped_latch_q | bus.i_night;
        case (state_q)
            AR_M:    if (expired) state_d = M_GRN;
            M_GRN:   if (expired && demand) state_d = M_YEL;
            M_YEL:   if (expired) state_d = AR_S;
            AR_S:    if (expired) state_d = bus.i_night ? FLASH : S_GRN;
            S_GRN:   if (expired) state_d = S_YEL;
            S_YEL:   if (expired) state_d = AR_M;
            FLASH: begin
                // Leave flash only as the lamps go dark, so the last flash is never cut short.
                if (expired) begin
                    f_d = ~f_q;
                    if (f_q && !bus.i_night) state_d = AR_M;
                end
            end
            default: state_d = AR_M;
        endcase
        if (state_d == FLASH && state_q != FLASH) f_d = 1'b1;

        if (state_d != state_q)     cnt_d = load_val(state_d);
        else if (!expired)          cnt_d = cnt_q - CNT_W'(1);
        else if (state_q == FLASH)  cnt_d = FLASH_LD;
        else                        cnt_d = '0;

        enter_sgrn  = (state_d == S_GRN) && (state_q != S_GRN);
        ped_latch_d = enter_sgrn ? 1'b0 : (ped_latch_q | bus.i_ped_req);
        if (enter_sgrn)            walk_active_d = ped_latch_q | bus.i_ped_req;
        else if (state_d == S_GRN) walk_active_d = walk_active_q;
        else                       walk_active_d = 1'b0;
    end

    always_comb begin
        bus.o_main  = 3'b100;
        bus.o_side  = 3'b100;
        bus.o_state = state_q;
        bus.o_walk  = 1'b0;
        case (state_q)
            M_GRN: bus.o_main = 3'b001;
            M_YEL: bus.o_main = 3'b010;
            S_GRN: begin
                bus.o_side = 3'b001;
                bus.o_walk = walk_active_q && (cnt_q >= WALK_THR);
            end
            S_YEL: bus.o_side = 3'b010;
            FLASH: begin
                bus.o_main = {1'b0, f_q, 1'b0};
                bus.o_side = {1'b0, f_q, 1'b0};
            end
            default: ;
        endcase
    end
endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: timer width in bits.
REQ-002 Parameter RED_CLR, default 2: all-red clearance duration, cycles.
REQ-003 Parameter MAIN_GREEN, default 20: minimum main-road green, cycles.
REQ-004 Parameter SIDE_GREEN, default 10: side-road green, cycles.
REQ-005 Parameter YELLOW, default 3: yellow duration for either road, cycles.
REQ-006 Parameter PED_WALK, default 8: walk duration, cycles.
REQ-007 Parameter FLASH_HALF, default 4: night-flash half-period, cycles.
REQ-008 clk  in  1  single clock; all state changes on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 i_side_req  in  1  side-road vehicle detector, level.
REQ-011 i_ped_req  in  1  pedestrian button, level or pulse.
REQ-012 i_night  in  1  night (flash) mode request, level.
REQ-013 o_main  out  3  main-road lamps {red,yellow,green}, one-hot or flash pattern.
REQ-014 o_side  out  3  side-road lamps {red,yellow,green}.
REQ-015 o_walk  out  1  pedestrian walk lamp (crossing the main road).
REQ-016 o_state  out  3  current state encoding, debug.

Function
REQ-017 States/encoding: AR_M=0, M_GRN=1, M_YEL=2, AR_S=3, S_GRN=4, S_YEL=5, FLASH=6; 7 unused, decodes to AR_M next cycle.
REQ-018 Timer: on every state entry, counter loads DURATION-1; decrements by 1 per cycle; a timed state exits on the edge where counter==0; each timed state therefore lasts exactly DURATION cycles.
REQ-019 Lamps are decoded from the state register only; they change on the same edge as the state, with no extra cycle of latency.
REQ-020 AR_M, AR_S: o_main=o_side=100; duration RED_CLR.
REQ-021 AR_M -> M_GRN on expiry.
REQ-022 M_GRN: o_main=001, o_side=100; after MAIN_GREEN cycles the counter holds at 0 and the state holds until demand = i_side_req | ped_latch | i_night; exits to M_YEL on the first edge with demand.
REQ-023 M_YEL: o_main=010, o_side=100; YELLOW cycles, then AR_S.
REQ-024 AR_S expiry: i_night=1 -> FLASH, else -> S_GRN.
REQ-025 S_GRN: o_main=100, o_side=001; SIDE_GREEN cycles, then S_YEL.
REQ-026 S_YEL: o_main=100, o_side=010; YELLOW cycles, then AR_M.
REQ-027 FLASH: o_main and o_side both = {0,f,0}, f toggles every FLASH_HALF cycles, starting at 1; o_walk=0.
REQ-028 FLASH exit: only on a toggle edge where f returns to 0 and i_night=0; next state AR_M.
REQ-029 ped_latch sets on any cycle with i_ped_req=1 and clears only on entry into S_GRN.
REQ-030 On S_GRN entry, walk_active = ped_latch | i_ped_req; o_walk=1 for the first PED_WALK cycles of S_GRN only when walk_active=1.
REQ-031 i_ped_req during S_GRN or S_YEL re-latches and is served on the next cycle through the side phase.
REQ-032 ped_latch persists through FLASH.
REQ-033 i_night change mid-phase has no effect until the next decision point (M_GRN demand, AR_S expiry, FLASH toggle).
REQ-034 Never may o_main and o_side both contain green or yellow outside FLASH; the bench asserts this every cycle.
REQ-035 Parameter constraints: all durations are >=1 and <2^CNT_W, and PED_WALK<=SIDE_GREEN; violations are a fatal elaboration-time check.

Reset
REQ-036 reset=1 forces immediately: state=AR_M, counter=RED_CLR-1, o_main=o_side=100, o_walk=0, ped_latch=0, walk_active=0, f=0, o_state=0.
REQ-037 Reset asserted mid-phase (including FLASH and during walk) aborts the phase with the REQ-036 values; there is no residual request memory.

Verification (defaults)
REQ-038 Release reset, all requests 0: AR_M for 2 cycles, then M_GRN held indefinitely (check >=100 cycles); no side green.
REQ-039 i_side_req=1 from reset: M_GRN 20 cycles, M_YEL 3, AR_S 2, S_GRN 10, S_YEL 3, AR_M 2, M_GRN; o_walk stays 0.
REQ-040 1-cycle i_ped_req pulse during M_YEL: S_GRN entered with o_walk=1 for exactly 8 cycles then 0 for 2; ped_latch=0 after entry.
REQ-041 i_ped_req pulse on the AR_S->S_GRN edge cycle: walk served in that same S_GRN; a second pulse in S_GRN is served on the following side phase.
REQ-042 i_night=1 in M_GRN after minimum time: sequence M_YEL, AR_S, FLASH; yellows toggle every 4 cycles; drop i_night: exit to AR_M only on a 1->0 toggle edge.
REQ-043 Assert reset during S_GRN with o_walk=1: outputs are 100/100/walk 0 in the same cycle; after release the sequence restarts per REQ-038.
